// File: rtl/tag_scan_unit.sv
// Scans a captured row-match vector and emits set-bit indices lowest-first,
// one per accepted handshake, with match count and completion pulse.
module tag_scan_unit #(
  parameter int DATA_DEPTH = 128,
  parameter int IDX_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_DEPTH-1:0] tag_in,
  input  logic [DATA_DEPTH-1:0] tag_tsc_in,
  input  logic                  sel_tsc,
  input  logic                  start,
  input  logic                  abort,
  output logic [IDX_W-1:0]      idx_out,
  output logic                  idx_valid,
  input  logic                  idx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W:0]        match_cnt,
  output logic                  any_match
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_DEPTH-1:0] pend, pend_clr, src;
  logic [IDX_W-1:0]      low_idx;
  logic                  hs, load;

  // Lowest set bit wins: scan from the top so the last hit overwrites.
  always_comb begin
    low_idx = '0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--)
      if (pend[i]) low_idx = IDX_W'(i);
  end

  // x & (x-1) drops exactly the lowest set bit, i.e. the one being handed out.
  assign pend_clr = pend & (pend - DATA_DEPTH'(1));
  assign src      = sel_tsc ? tag_tsc_in : tag_in;
  assign hs       = idx_valid & idx_ready;
  assign load     = (state == IDLE) & start & ~abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_valid = 1'b0;
    idx_out   = '0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    if (state == SCAN) begin
      idx_valid = |pend;
      idx_out   = low_idx;
    end
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = SCAN;
        // Retiring the last index goes straight to DONE; an empty capture
        // spends one idle SCAN cycle first.
        SCAN:    if (!(|pend) || (hs && !(|pend_clr))) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= '0;
      match_cnt <= '0;
      any_match <= 1'b0;
    end else if (abort) begin
      pend      <= '0;
    end else if (load) begin
      pend      <= src;
      match_cnt <= '0;
      any_match <= |src;
    end else if (hs) begin
      pend      <= pend_clr;
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tag_scan_unit.sv
// Self-checking bench for tag_scan_unit: vector table, randomized scans against
// a queue-based model, and hand sequences for abort/start-ignore/reset.
module tb_tag_scan_unit;
  localparam int DD = 128;
  localparam int IW = 7;

  logic          clk = 1'b0, rst = 1'b0;
  logic [DD-1:0] tag_in = '0, tag_tsc_in = '0;
  logic          sel_tsc = 1'b0, start = 1'b0, abort = 1'b0, idx_ready = 1'b0;
  logic [IW-1:0] idx_out;
  logic          idx_valid, busy, done, any_match;
  logic [IW:0]   match_cnt;

  int n_chk = 0, n_fail = 0;

  tag_scan_unit #(.DATA_DEPTH(DD), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .tag_in(tag_in), .tag_tsc_in(tag_tsc_in),
    .sel_tsc(sel_tsc), .start(start), .abort(abort), .idx_out(idx_out),
    .idx_valid(idx_valid), .idx_ready(idx_ready), .busy(busy), .done(done),
    .match_cnt(match_cnt), .any_match(any_match)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DD-1:0] vec;
    bit            sel;
    int            mode;     // 0: ready always, 1: ready toggles from 0, 2: random
    int            exp_cnt;
    bit            exp_any;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DD-1:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge. Model: ordered queue of set bit positions; one pops
  // per cycle where an index is offered and ready is high.
  task automatic run_scan(input logic [DD-1:0] vec, input bit sel, input int mode,
                          output int cnt_dut, output bit any_dut);
    int q[$];
    int cnt;
    bit r, fin;
    if (sel) begin tag_tsc_in = vec; tag_in = junk(); end
    else     begin tag_in = vec; tag_tsc_in = junk(); end
    sel_tsc = sel; start = 1'b1; idx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; tag_in = junk(); tag_tsc_in = junk(); sel_tsc = $urandom;
    for (int i = 0; i < DD; i++) if (vec[i]) q.push_back(i);
    cnt = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 6 * DD + 8 && !fin; cyc++) begin
      chk("busy_scan", busy, 1);
      chk("done_scan", done, 0);
      chk("valid_scan", idx_valid, q.size() > 0);
      if (q.size() == 0) begin
        idx_ready = $urandom;
        @(negedge clk);
        fin = 1'b1;
      end else begin
        chk("idx", idx_out, q[0]);
        r = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 99) < 60);
        idx_ready = r;
        @(negedge clk);
        if (r) begin
          void'(q.pop_front());
          cnt++;
          if (q.size() == 0) fin = 1'b1;
        end
      end
    end
    if (!fin) chk("scan_timeout", 0, 1);
    idx_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("valid_done", idx_valid, 0);
    chk("idx_done", idx_out, 0);
    chk("cnt_done", match_cnt, cnt);
    chk("any_done", any_match, vec != '0);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("busy_idle", busy, 0);
    chk("cnt_hold", match_cnt, cnt);
    cnt_dut = match_cnt;
    any_dut = any_match;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   c;
    bit   a;
    logic [DD-1:0] tmp;

    v.vec = 128'h91;        v.sel = 0; v.mode = 0; v.exp_cnt = 3;   v.exp_any = 1; tbl.push_back(v);
    v.vec = '0; v.vec[127] = 1'b1;
                            v.sel = 1; v.mode = 1; v.exp_cnt = 1;   v.exp_any = 1; tbl.push_back(v);
    v.vec = '0;             v.sel = 0; v.mode = 0; v.exp_cnt = 0;   v.exp_any = 0; tbl.push_back(v);
    v.vec = '1;             v.sel = 0; v.mode = 0; v.exp_cnt = 128; v.exp_any = 1; tbl.push_back(v);
    v.vec = 128'h8000_0000_0000_0001_0000_0000_0000_0001;
                            v.sel = 1; v.mode = 2; v.exp_cnt = 3;   v.exp_any = 1; tbl.push_back(v);

    // Reset state, then start on the very first edge after release.
    #12;
    chk("rst_busy", busy, 0);  chk("rst_valid", idx_valid, 0); chk("rst_idx", idx_out, 0);
    chk("rst_done", done, 0);  chk("rst_cnt", match_cnt, 0);   chk("rst_any", any_match, 0);
    @(negedge clk); rst = 1'b1;

    foreach (tbl[k]) begin
      run_scan(tbl[k].vec, tbl[k].sel, tbl[k].mode, c, a);
      chk($sformatf("tbl%0d_cnt", k), c, tbl[k].exp_cnt);
      chk($sformatf("tbl%0d_any", k), a, tbl[k].exp_any);
    end

    for (int k = 0; k < 8; k++) begin
      tmp = junk();
      if (k[0]) tmp = tmp & junk() & junk();
      run_scan(tmp, k[1], 2, c, a);
      chk("rnd_cnt", c, $countones(tmp));
    end

    // Abort after two accepted indices.
    tag_in = 128'hF0F; sel_tsc = 0; start = 1; idx_ready = 0;
    @(negedge clk); start = 0;
    chk("ab_idx0", idx_out, 0); idx_ready = 1;
    @(negedge clk); chk("ab_idx1", idx_out, 1);
    @(negedge clk); chk("ab_idx2", idx_out, 2); chk("ab_cnt2", match_cnt, 2);
    idx_ready = 0; abort = 1;
    @(negedge clk); abort = 0;
    chk("ab_busy", busy, 0); chk("ab_valid", idx_valid, 0);
    chk("ab_done", done, 0); chk("ab_cnt", match_cnt, 2);
    @(negedge clk);
    chk("ab_nodone", done, 0); chk("ab_cnt_hold", match_cnt, 2);
    // abort beats start in IDLE
    start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    chk("ab_pri_busy", busy, 0); chk("ab_pri_cnt", match_cnt, 2);

    // start during SCAN is ignored
    tag_in = 128'h6; start = 1; idx_ready = 0;
    @(negedge clk); start = 0;
    chk("ig_idx_a", idx_out, 1);
    tag_in = 128'h1; start = 1;
    @(negedge clk); start = 0;
    chk("ig_idx_b", idx_out, 1); chk("ig_valid", idx_valid, 1); chk("ig_cnt", match_cnt, 0);
    idx_ready = 1;
    @(negedge clk); chk("ig_idx_c", idx_out, 2);
    @(negedge clk); idx_ready = 0;
    chk("ig_done", done, 1); chk("ig_cnt_end", match_cnt, 2);
    @(negedge clk); chk("ig_idle", busy, 0);

    // Reset mid-scan takes effect without a clock edge.
    tag_in = '1; start = 1; idx_ready = 1;
    @(negedge clk); start = 0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mr_busy", busy, 0);  chk("mr_valid", idx_valid, 0); chk("mr_idx", idx_out, 0);
    chk("mr_done", done, 0);  chk("mr_cnt", match_cnt, 0);   chk("mr_any", any_match, 0);
    idx_ready = 0;
    @(negedge clk); rst = 1'b1;
    run_scan(128'h91, 0, 0, c, a);
    chk("mr_rescan_cnt", c, 3);
    chk("mr_rescan_any", a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tag_scan_unit.md
TAG_SCAN_UNIT -- requirements
Module: tag_scan_unit

Interface
REQ-001 The block SHALL have parameter DATA_DEPTH, default 128, giving the number of AP rows (tag width).
REQ-002 The block SHALL have parameter IDX_W, default 7, giving the row index width, equal to clog2(DATA_DEPTH).
REQ-003 The block SHALL have port clk, input, width 1, system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1, asynchronous active-low reset.
REQ-005 The block SHALL have port tag_in, input, width DATA_DEPTH, registered row-match vector from the tag stage.
REQ-006 The block SHALL have port tag_tsc_in, input, width DATA_DEPTH, registered TSC match vector from the tag stage.
REQ-007 The block SHALL have port sel_tsc, input, width 1, source select sampled with start: 0 = tag_in, 1 = tag_tsc_in.
REQ-008 The block SHALL have port start, input, width 1, scan request pulse.
REQ-009 The block SHALL have port abort, input, width 1, cancels any scan.
REQ-010 The block SHALL have port idx_out, output, width IDX_W, index of the current matching row.
REQ-011 The block SHALL have port idx_valid, output, width 1, meaning idx_out is valid.
REQ-012 The block SHALL have port idx_ready, input, width 1, consumer accepts idx_out.
REQ-013 The block SHALL have port busy, output, width 1, high in any state other than IDLE.
REQ-014 The block SHALL have port done, output, width 1, one-cycle pulse at scan completion.
REQ-015 The block SHALL have port match_cnt, output, width IDX_W+1, number of indices accepted in the current or last scan.
REQ-016 The block SHALL have port any_match, output, width 1, high when the captured vector was nonzero.

Function
REQ-017 FSM states SHALL be IDLE, SCAN and DONE.
REQ-018 In IDLE, start=1 with abort=0 SHALL load pend <= (sel_tsc ? tag_tsc_in : tag_in), clear match_cnt, set any_match = |source, and go to SCAN on the next edge.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 In SCAN, idx_valid SHALL equal (pend != 0), and idx_out SHALL be the lowest-numbered set bit of pend, combinational from the registered pend.
REQ-021 In SCAN, a handshake (idx_valid & idx_ready) SHALL clear that bit of pend and increment match_cnt on the same edge; the next index appears the following cycle, giving one index per cycle under continuous ready.
REQ-022 While idx_valid=1 and idx_ready=0, idx_out and pend SHALL hold stable.
REQ-023 In SCAN, pend == 0 SHALL cause a transition to DONE; a zero captured vector therefore gives SCAN (1 cycle, idx_valid=0) -> DONE.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, followed by a transition to IDLE; match_cnt and any_match hold until the next start or reset.
REQ-025 abort=1 in any state SHALL, on the next edge, go to IDLE and clear pend with no done pulse; match_cnt SHALL hold its partial value.
REQ-026 abort SHALL have priority over start when both are asserted in IDLE.
REQ-027 When all DATA_DEPTH bits are set, match_cnt SHALL reach DATA_DEPTH (128) without wrap.
REQ-028 Outside SCAN, idx_valid SHALL be 0 and idx_out SHALL be 0.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, pend=0, match_cnt=0, any_match=0, idx_valid=0, idx_out=0, busy=0 and done=0, including mid-scan.
REQ-030 After rst is released, the block SHALL accept start on the first clock edge.

Verification
REQ-031 Bench SHALL cover: tag_in=0x...0000_0091 (bits 0,4,7), start, ready=1 -> idx_out 0,4,7 on consecutive cycles, done pulse the cycle after the last index, match_cnt=3, any_match=1.
REQ-032 Bench SHALL cover: sel_tsc=1, tag_tsc_in bit 127 only, ready toggled 0/1 -> idx_out=127 held stable while ready=0, accepted once, match_cnt=1.
REQ-033 Bench SHALL cover: zero vector, start -> no idx_valid, done 2 cycles after start, match_cnt=0, any_match=0.
REQ-034 Bench SHALL cover: all-ones vector, ready=1 -> 128 indices 0..127 in order, match_cnt=128, done once.
REQ-035 Bench SHALL cover: abort asserted after 2 accepted indices -> IDLE next cycle, no done, match_cnt=2; and start during SCAN -> ignored.
REQ-036 Bench SHALL cover: rst pulled low mid-scan -> all outputs 0 immediately; a new start after release scans correctly.
